// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage and a debug/loader master.
// The CPU has fixed priority; a starved debug request forces a one-cycle pipeline stall.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FORCE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0]     dbg_rdata_q, dbg_rdata_d;
    logic            cpu_access;

    assign cpu_access = cpu_memread | cpu_memwrite;
    assign cpu_rdata  = mem_rdata;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Arbitration, memory mux and starvation tracking
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = '0;
        cpu_stall    = 1'b0;
        dbg_gnt      = 1'b0;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        mem_read     = cpu_memread;
        mem_write    = cpu_memwrite;

        unique case (state_q)
            IDLE: begin
                if (dbg_req && !cpu_access) begin
                    dbg_gnt = 1'b1;
                end else if (dbg_req) begin
                    if (starve_cnt_q == CW'(STARVE_LIMIT - 1)) begin
                        state_d = FORCE;
                    end else begin
                        starve_cnt_d = starve_cnt_q + CW'(1);
                    end
                end
            end
            FORCE: begin
                state_d = IDLE;
                if (dbg_req) begin
                    cpu_stall = 1'b1;
                    dbg_gnt   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_read  = ~dbg_we;
            mem_write = dbg_we;
        end

        // Reset masks every control strobe so no access lands in the reset cycle
        if (reset) begin
            cpu_stall = 1'b0;
            dbg_gnt   = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end

        dbg_rvalid_d = dbg_gnt & ~dbg_we;
        dbg_rdata_d  = (dbg_gnt && !dbg_we) ? mem_rdata : dbg_rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_memread, cpu_memwrite, cpu_stall;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] mem [0:255];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

    dmem_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_memread(cpu_memread),
        .cpu_memwrite(cpu_memwrite), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h08] = 32'h12345678;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        mem[3] = 32'h44444444;

        reset = 1'b1;
        cpu_addr = 32'h20; cpu_wdata = 32'h5; cpu_memread = 1'b1; cpu_memwrite = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40; dbg_wdata = 32'h0;
        settle();
        chk("rst_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mrd", 32'(mem_read), 32'd0);
        chk("rst_mwr", 32'(mem_write), 32'd0);
        chk("rst_maddr", mem_addr, 32'h20);
        tick();
        chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'h0);

        // Idle-memory debug read
        reset = 1'b0; cpu_memread = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
        settle();
        chk("idle_gnt", 32'(dbg_gnt), 32'd1);
        chk("idle_mrd", 32'(mem_read), 32'd1);
        chk("idle_maddr", mem_addr, 32'h40);
        chk("idle_stall", 32'(cpu_stall), 32'd0);
        tick();
        dbg_req = 1'b0;
        settle();
        chk("idle_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("idle_rdata", dbg_rdata, 32'hDEADBEEF);
        tick();
        chk("idle_rvalid_off", 32'(dbg_rvalid), 32'd0);

        // CPU load passes straight through
        cpu_memread = 1'b1; cpu_addr = 32'h20;
        settle();
        chk("ld_rdata", cpu_rdata, 32'h12345678);
        chk("ld_stall", 32'(cpu_stall), 32'd0);
        chk("ld_mwr", 32'(mem_write), 32'd0);
        tick();

        // Saturated CPU stores vs debug write: forced grant on cycle 8
        cpu_memread = 1'b0; cpu_memwrite = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'h2;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("sat_gnt%0d", i), 32'(dbg_gnt), 32'd0);
            chk($sformatf("sat_stall%0d", i), 32'(cpu_stall), 32'd0);
            chk($sformatf("sat_wd%0d", i), mem_wdata, 32'h1);
            tick();
        end
        settle();
        chk("force_gnt", 32'(dbg_gnt), 32'd1);
        chk("force_stall", 32'(cpu_stall), 32'd1);
        chk("force_mwr", 32'(mem_write), 32'd1);
        chk("force_wd", mem_wdata, 32'h2);
        tick();
        dbg_req = 1'b0;
        settle();
        chk("after_gnt", 32'(dbg_gnt), 32'd0);
        chk("after_stall", 32'(cpu_stall), 32'd0);
        chk("after_wd", mem_wdata, 32'h1);
        chk("after_rvalid", 32'(dbg_rvalid), 32'd0);
        tick();
        cpu_memwrite = 1'b0;
        settle();
        chk("sat_mem", mem[8'h04], 32'h1);

        // Counter clear: 5 denied, grant on idle cycle, fresh request sees 7 denials without force
        cpu_memread = 1'b1; cpu_addr = 32'h20; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("clr_deny%0d", i), 32'(dbg_gnt), 32'd0);
            tick();
        end
        cpu_memread = 1'b0;
        settle();
        chk("clr_gnt", 32'(dbg_gnt), 32'd1);
        tick();
        chk("clr_cnt", 32'(dut.starve_cnt_q), 32'd0);
        cpu_memread = 1'b1;
        for (int i = 0; i < 7; i++) begin
            settle();
            chk($sformatf("clr_nogrant%0d", i), 32'(dbg_gnt), 32'd0);
            chk($sformatf("clr_nostall%0d", i), 32'(cpu_stall), 32'd0);
            tick();
        end
        dbg_req = 1'b0;
        settle();
        chk("clr_drop_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("clr_drop_cnt", 32'(dut.starve_cnt_q), 32'd0);

        // Reset asserted in the FORCE cycle
        cpu_memread = 1'b0; cpu_memwrite = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hAA;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h34; dbg_wdata = 32'hBB;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        settle();
        chk("rf_mwr", 32'(mem_write), 32'd0);
        chk("rf_gnt", 32'(dbg_gnt), 32'd0);
        chk("rf_stall", 32'(cpu_stall), 32'd0);
        tick();
        reset = 1'b0; cpu_memwrite = 1'b0; dbg_req = 1'b0;
        settle();
        chk("rf_state", 32'(dut.state_q), 32'd0);
        chk("rf_cnt", 32'(dut.starve_cnt_q), 32'd0);
        chk("rf_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rf_nowrite", mem[8'h0D], 32'h0);
        tick();

        // Back-to-back debug reads with idle CPU
        dbg_req = 1'b1; dbg_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 32'(i * 4);
            settle();
            chk($sformatf("b2b_gnt%0d", i), 32'(dbg_gnt), 32'd1);
            if (i > 0) begin
                chk($sformatf("b2b_rv%0d", i - 1), 32'(dbg_rvalid), 32'd1);
                chk($sformatf("b2b_rd%0d", i - 1), dbg_rdata, 32'(32'h11111111 * i));
            end
            tick();
        end
        dbg_req = 1'b0;
        settle();
        chk("b2b_rv3", 32'(dbg_rvalid), 32'd1);
        chk("b2b_rd3", dbg_rdata, 32'h44444444);
        tick();
        chk("b2b_rv_end", 32'(dbg_rvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
